rv_register_file: RTL and testbench

- RV32 integer register file: 32 architectural registers, two combinational read ports, one synchronous write port.
- Instantiated by the decode stage.
  - Read addresses come from the decode stage's latched rs1/rs2 fields.
  - Write port is driven by the writeback stage.
- Register x0 is hardwired to zero.

---
 rtl/rv_register_file.sv | 71 +++++++
 tb/tb_rv_register_file.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rv_register_file.sv
// RV32 integer register file: 2**ADDR_WIDTH x WORD_SIZE, x0 hardwired to zero,
// two combinational read ports, one synchronous write port. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module rv_register_file #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WORD_SIZE-1:0]  write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [WORD_SIZE-1:0]  read_data1,
    output logic [WORD_SIZE-1:0]  read_data2
);

    localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int NUM_PORTS = 2;

    logic [WORD_SIZE-1:0]  w_regs     [NUM_REGS];
    logic [NUM_REGS-1:0]   w_wr_sel;
    logic                  w_wr_active;
    logic [ADDR_WIDTH-1:0] w_raddr    [NUM_PORTS];
    logic [WORD_SIZE-1:0]  w_rdata    [NUM_PORTS];

    // Writes to x0 are folded out here so neither storage nor forwarding ever sees them;
    // only a definite 1 on write_enable counts as a write.
    assign w_wr_active = reset_n && (write_enable == 1'b1) && (write_addr != '0);

    assign w_regs[0]   = '0;
    assign w_wr_sel[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [WORD_SIZE-1:0] r_value = '0;

            assign w_wr_sel[gi] = w_wr_active && (write_addr == ADDR_WIDTH'(gi));

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_value <= '0;
                end else if (w_wr_sel[gi]) begin
                    r_value <= write_data;
                end
            end

            assign w_regs[gi] = r_value;
        end
    endgenerate

    assign w_raddr[0] = read_addr1;
    assign w_raddr[1] = read_addr2;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            always_comb begin
                w_rdata[gi] = w_regs[w_raddr[gi]];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_active && (w_raddr[gi] == write_addr)) begin
                    w_rdata[gi] = write_data;
                end
`endif
            end
        end
    endgenerate

    assign read_data1 = w_rdata[0];
    assign read_data2 = w_rdata[1];

endmodule

// File: tb/tb_rv_register_file.sv
// Scoreboard bench for rv_register_file: stimulus pushes expected reads, a negedge monitor pops and compares.
module tb_rv_register_file;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          txn;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    int          txn_cnt = 0;

    rv_register_file #(.WORD_SIZE(32), .ADDR_WIDTH(5)) dut (
        .clock        (clk),
        .reset_n      (reset_n),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .read_data1   (read_data1),
        .read_data2   (read_data2)
    );

    always #5 clk = ~clk;

    // Architectural view of a read in the cycle before the edge.
    function automatic logic [31:0] expect_read(input logic [4:0] ra, input logic rst_n,
                                                input logic we, input logic [4:0] wa,
                                                input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n && we && wa == ra) return wd;
`endif
        return model[ra];
    endfunction

    task automatic drive(input logic rst_n, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n      = rst_n;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr1   = ra1;
        read_addr2   = ra2;
        e.txn = txn_cnt;
        e.a1  = ra1;
        e.a2  = ra2;
        e.e1  = expect_read(ra1, rst_n, we, wa, wd);
        e.e2  = expect_read(ra2, rst_n, we, wa, wd);
        sb_q.push_back(e);
        txn_cnt++;
        // Model state after the coming edge.
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
    endtask

    // Monitor: the read ports present a result every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (read_data1 !== e.e1) begin
                    errors++;
                    $display("FAIL rd1 txn=%0d addr=%0d got=%h exp=%h", e.txn, e.a1, read_data1, e.e1);
                end
                checks++;
                if (read_data2 !== e.e2) begin
                    errors++;
                    $display("FAIL rd2 txn=%0d addr=%0d got=%h exp=%h", e.txn, e.a2, read_data2, e.e2);
                end
                $display("txn %0d: ra1=%0d rd1=%h ra2=%0d rd2=%h", e.txn, e.a1, read_data1, e.a2, read_data2);
            end
        end
    end

    initial begin
        logic        r_rst;
        logic        r_we;
        logic [4:0]  r_wa;
        logic [4:0]  r_a1;
        logic [4:0]  r_a2;
        logic [31:0] r_wd;

        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset_n      = 1'b1;
        write_enable = 1'b0;
        write_addr   = 5'd0;
        write_data   = 32'h0;
        read_addr1   = 5'd0;
        read_addr2   = 5'd0;

        // Time-zero contents are zero even before any reset.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31);

        // Fill x1..x31, then reset and read every address back.
        for (int i = 1; i < 32; i++)
            drive(1'b1, 1'b1, 5'(i), 32'hA5000000 | 32'(i), 5'(i), 5'(i - 1));
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
        for (int i = 0; i < 32; i++)
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // Write/read x5.
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

        // x0 write ignored.
        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // write_enable low holds x7.
        drive(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 5'd7, 32'hAAAAAAAA, 5'd7, 5'd7);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

        // Collision on x3, port 2 on another address to show per-port independence.
        drive(1'b1, 1'b1, 5'd3, 32'h11111111, 5'd0, 5'd5);
        drive(1'b1, 1'b1, 5'd3, 32'h22222222, 5'd3, 5'd5);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);

        // Reset wins over a simultaneous write to x9.
        drive(1'b1, 1'b1, 5'd9, 32'h01010101, 5'd9, 5'd3);
        drive(1'b0, 1'b1, 5'd9, 32'h55555555, 5'd9, 5'd3);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd3);

        // Randomized traffic, addresses biased toward a few registers to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(0, 59) != 0);
            r_we  = ($urandom_range(0, 3) != 0);
            r_wa  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r_a1  = ($urandom_range(0, 2) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_a2  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r_wd  = $urandom;
            drive(r_rst, r_we, r_wa, r_wd, r_a1, r_a2);
        end

        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
